// File: rtl/m_registers.sv
// m_registers -- datapath registers for an iterative restoring divider.
//
// Holds the remainder (R), the left-aligned divisor (D) and the quotient (Z).
// Each register is updated on the rising edge of clk according to its own
// select; all three selects act independently in the same cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset, clears R, D and Z
//   mux_R      in   remainder select: KEEP, A, A_NEG, SUB_KEEP
//   mux_D      in   divisor select:   KEEP, B, B_NEG, SHR
//   mux_Z      in   quotient select:  KEEP, ZERO, SHL_ADD (code 3 = KEEP)
//   rs1        in   dividend operand
//   rs2        in   divisor operand
//   sub_result in   external subtractor result, bit 31 is the sign
//   R          out  remainder register
//   D          out  divisor register, operand aligned to D[62:31]
//   Z          out  quotient register
//
// Configuration macro:
//   M_REGISTERS_NEG_EN  when defined, A_NEG / B_NEG load the two's-complement
//                       negation of rs1 / rs2. When undefined, those codes
//                       hold the register and no negation logic is built.
//
// Select encodings come from the shared m_definitions macros; defaults are
// provided here so the file also stands alone.

`ifndef MUX_R_LENGTH
`define MUX_R_LENGTH   2
`endif
`ifndef MUX_R_KEEP
`define MUX_R_KEEP     2'd0
`endif
`ifndef MUX_R_A
`define MUX_R_A        2'd1
`endif
`ifndef MUX_R_A_NEG
`define MUX_R_A_NEG    2'd2
`endif
`ifndef MUX_R_SUB_KEEP
`define MUX_R_SUB_KEEP 2'd3
`endif

`ifndef MUX_D_LENGTH
`define MUX_D_LENGTH   2
`endif
`ifndef MUX_D_KEEP
`define MUX_D_KEEP     2'd0
`endif
`ifndef MUX_D_B
`define MUX_D_B        2'd1
`endif
`ifndef MUX_D_B_NEG
`define MUX_D_B_NEG    2'd2
`endif
`ifndef MUX_D_SHR
`define MUX_D_SHR      2'd3
`endif

`ifndef MUX_Z_LENGTH
`define MUX_Z_LENGTH   2
`endif
`ifndef MUX_Z_KEEP
`define MUX_Z_KEEP     2'd0
`endif
`ifndef MUX_Z_ZERO
`define MUX_Z_ZERO     2'd1
`endif
`ifndef MUX_Z_SHL_ADD
`define MUX_Z_SHL_ADD  2'd2
`endif

module m_registers (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [`MUX_R_LENGTH-1:0] mux_R,
  input  logic [`MUX_D_LENGTH-1:0] mux_D,
  input  logic [`MUX_Z_LENGTH-1:0] mux_Z,
  input  logic [31:0]              rs1,
  input  logic [31:0]              rs2,
  input  logic [31:0]              sub_result,
  output logic [31:0]              R,
  output logic [62:0]              D,
  output logic [31:0]              Z
);

  logic [31:0] r_next;
  logic [62:0] d_next;
  logic [31:0] z_next;

  // A non-negative subtraction result means the divisor "fit": the remainder
  // takes the difference and the quotient shifts in a 1.
  logic sub_fits;
  assign sub_fits = ~sub_result[31];

`ifdef M_REGISTERS_NEG_EN
  logic [31:0] rs1_neg;
  logic [31:0] rs2_neg;
  // Modulo-2^32 negation: 0x80000000 maps to itself.
  assign rs1_neg = ~rs1 + 32'd1;
  assign rs2_neg = ~rs2 + 32'd1;
`endif

  always_comb begin
    r_next = R;
    case (mux_R)
      `MUX_R_A:        r_next = rs1;
      `MUX_R_A_NEG: begin
`ifdef M_REGISTERS_NEG_EN
        r_next = rs1_neg;
`endif
      end
      `MUX_R_SUB_KEEP: if (sub_fits) r_next = sub_result;
      default:         r_next = R;
    endcase
  end

  always_comb begin
    d_next = D;
    case (mux_D)
      `MUX_D_B:      d_next = {rs2, 31'b0};
      `MUX_D_B_NEG: begin
`ifdef M_REGISTERS_NEG_EN
        d_next = {rs2_neg, 31'b0};
`endif
      end
      `MUX_D_SHR:    d_next = {1'b0, D[62:1]};
      default:       d_next = D;
    endcase
  end

  always_comb begin
    z_next = Z;
    case (mux_Z)
      `MUX_Z_ZERO:    z_next = 32'd0;
      `MUX_Z_SHL_ADD: z_next = {Z[30:0], sub_fits};
      default:        z_next = Z;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      R <= 32'd0;
      D <= 63'd0;
      Z <= 32'd0;
    end else begin
      R <= r_next;
      D <= d_next;
      Z <= z_next;
    end
  end

endmodule

// File: tb/tb_m_registers.sv
// Self-checking bench for m_registers: reset checks, a directed vector table,
// an asynchronous mid-sequence reset, then randomized traffic checked against
// an arithmetic reference model. Expectations for A_NEG / B_NEG follow
// whether M_REGISTERS_NEG_EN is defined for the build.
module tb_m_registers;

`ifdef M_REGISTERS_NEG_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [1:0]  mux_R, mux_D, mux_Z;
  logic [31:0] rs1, rs2, sub_result;
  logic [31:0] R;
  logic [62:0] D;
  logic [31:0] Z;

  m_registers dut (
    .clk(clk), .resetn(resetn),
    .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
    .rs1(rs1), .rs2(rs2), .sub_result(sub_result),
    .R(R), .D(D), .Z(Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  mr, md, mz;
    logic [31:0] a, b, s;
    logic [31:0] er;
    logic [62:0] ed;
    logic [31:0] ez;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, logic [1:0] mr, logic [1:0] md, logic [1:0] mz,
                              logic [31:0] a, logic [31:0] b, logic [31:0] s,
                              logic [31:0] er, logic [62:0] ed, logic [31:0] ez);
    vec_t v;
    v.name = nm; v.mr = mr; v.md = md; v.mz = mz;
    v.a = a; v.b = b; v.s = s; v.er = er; v.ed = ed; v.ez = ez;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] mr, input logic [1:0] md, input logic [1:0] mz,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    mux_R = mr; mux_D = md; mux_Z = mz; rs1 = a; rs2 = b; sub_result = s;
  endtask

  // Reference model state: plain unsigned arithmetic on 64-bit integers.
  longint unsigned m_r, m_d, m_z;
  localparam longint unsigned M32 = 64'h1_0000_0000;
  localparam longint unsigned H31 = 64'h8000_0000;

  function automatic void model_step(logic [1:0] mr, logic [1:0] md, logic [1:0] mz,
                                     longint unsigned a, longint unsigned b, longint unsigned s);
    longint unsigned nr, nd, nz;
    bit fits;
    fits = (s < H31);
    nr = m_r; nd = m_d; nz = m_z;
    case (mr)
      2'd1: nr = a;
      2'd2: if (NEG) nr = (M32 - a) % M32;
      2'd3: if (fits) nr = s;
      default: ;
    endcase
    case (md)
      2'd1: nd = b * H31;
      2'd2: if (NEG) nd = ((M32 - b) % M32) * H31;
      2'd3: nd = m_d / 2;
      default: ;
    endcase
    case (mz)
      2'd1: nz = 0;
      2'd2: nz = (m_z * 2 + (fits ? 1 : 0)) % M32;
      default: ;
    endcase
    m_r = nr; m_d = nd; m_z = nz;
  endfunction

  initial begin
    logic [31:0] r2;
    logic [62:0] d8, d9, d19;
    logic [31:0] r19;
    int unsigned sel;
    logic [31:0] ra, rb, rsub;

    resetn = 1'b0;
    drive(2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_R", {32'd0, R}, 64'd0);
    chk("reset_D", {1'b0, D}, 64'd0);
    chk("reset_Z", {32'd0, Z}, 64'd0);
    #2 resetn = 1'b1;

    r2  = NEG ? 32'd7890 : 32'd789;
    d8  = NEG ? (63'd4567 << 31) : (63'd456 << 31);
    d9  = d8 >> 1;
    r19 = NEG ? 32'h8000_0000 : 32'd5;
    d19 = NEG ? (63'h8000_0000 << 31) : (63'd3 << 30);

    //   name            mR    mD    mZ    rs1           rs2            sub            R             D               Z
    add("load_a",        2'd1, 2'd0, 2'd0, 32'd789,      32'd0,         32'd0,         32'd789,      63'd0,          32'd0);
    add("load_a_neg",    2'd2, 2'd0, 2'd0, -32'sd7890,   32'd0,         32'd0,         r2,           63'd0,          32'd0);
    add("sub_neg_hold",  2'd3, 2'd0, 2'd0, 32'd0,        32'd0,         -32'sd123,     r2,           63'd0,          32'd0);
    add("sub_pos_load",  2'd3, 2'd0, 2'd0, 32'd0,        32'd0,         32'd123,       32'd123,      63'd0,          32'd0);
    add("r_keep",        2'd0, 2'd0, 2'd0, 32'd55,       32'd0,         32'd9,         32'd123,      63'd0,          32'd0);
    add("load_b",        2'd0, 2'd1, 2'd0, 32'd0,        32'd456,       32'd0,         32'd123,      63'd456 << 31,  32'd0);
    add("d_keep",        2'd0, 2'd0, 2'd0, 32'd0,        32'd99,        32'd0,         32'd123,      63'd456 << 31,  32'd0);
    add("load_b_neg",    2'd0, 2'd2, 2'd0, 32'd0,        -32'sd4567,    32'd0,         32'd123,      d8,             32'd0);
    add("d_shr",         2'd0, 2'd3, 2'd0, 32'd0,        32'd0,         32'd0,         32'd123,      d9,             32'd0);
    add("z_zero",        2'd0, 2'd0, 2'd1, 32'd0,        32'd0,         32'd0,         32'd123,      d9,             32'd0);
    add("z_shl_1",       2'd0, 2'd0, 2'd2, 32'd0,        32'd0,         32'd123,       32'd123,      d9,             32'd1);
    add("z_keep",        2'd0, 2'd0, 2'd0, 32'd0,        32'd0,         32'd123,       32'd123,      d9,             32'd1);
    add("z_shl_2",       2'd0, 2'd0, 2'd2, 32'd0,        32'd0,         -32'sd123,     32'd123,      d9,             32'd2);
    add("z_shl_5",       2'd0, 2'd0, 2'd2, 32'd0,        32'd0,         32'd123,       32'd123,      d9,             32'd5);
    add("z_shl_11",      2'd0, 2'd0, 2'd2, 32'd0,        32'd0,         32'd123,       32'd123,      d9,             32'd11);
    add("z_shl_22",      2'd0, 2'd0, 2'd2, 32'd0,        32'd0,         32'h8000_0000, 32'd123,      d9,             32'd22);
    add("all_three",     2'd1, 2'd1, 2'd2, 32'h1234,     32'd3,         32'h7fff_ffff, 32'h1234,     63'd3 << 31,    32'd45);
    add("all_shared",    2'd3, 2'd3, 2'd2, 32'd0,        32'd0,         32'd5,         32'd5,        63'd3 << 30,    32'd91);
    add("neg_min",       2'd2, 2'd2, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'd0,        r19,          d19,            32'd91);
    add("z_code3",       2'd0, 2'd0, 2'd3, 32'd0,        32'd0,         32'd0,         r19,          d19,            32'd91);

    foreach (vecs[i]) begin
      drive(vecs[i].mr, vecs[i].md, vecs[i].mz, vecs[i].a, vecs[i].b, vecs[i].s);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_R"}, {32'd0, R}, {32'd0, vecs[i].er});
      chk({vecs[i].name, "_D"}, {1'b0, D}, {1'b0, vecs[i].ed});
      chk({vecs[i].name, "_Z"}, {32'd0, Z}, {32'd0, vecs[i].ez});
    end

    // Asynchronous reset between edges clears everything without a clock.
    drive(2'd1, 2'd1, 2'd2, 32'd99, 32'd77, 32'd1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("async_rst_R", {32'd0, R}, 64'd0);
    chk("async_rst_D", {1'b0, D}, 64'd0);
    chk("async_rst_Z", {32'd0, Z}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_R", {32'd0, R}, 64'd0);
    chk("rst_hold_Z", {32'd0, Z}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    drive(2'd1, 2'd1, 2'd1, 32'd42, 32'd7, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_R", {32'd0, R}, 64'd42);
    chk("post_rst_D", {1'b0, D}, 64'd7 << 31);
    chk("post_rst_Z", {32'd0, Z}, 64'd0);

    m_r = 42; m_d = 64'd7 << 31; m_z = 0;
    for (int n = 0; n < 300; n++) begin
      sel  = $urandom;
      ra   = ((sel & 32'h30) == 0) ? 32'h8000_0000 : $urandom;
      rb   = ((sel & 32'hc0) == 0) ? 32'd0 : $urandom;
      rsub = $urandom;
      drive(sel[1:0], sel[3:2], sel[5:4], ra, rb, rsub);
      model_step(sel[1:0], sel[3:2], sel[5:4], ra, rb, rsub);
      @(posedge clk);
      #1;
      chk("rand_R", {32'd0, R}, m_r);
      chk("rand_D", {1'b0, D}, m_d);
      chk("rand_Z", {32'd0, Z}, m_z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
